bipbip_tweak_sched: RTL
=======================

# bipbip_tweak_sched

Iterative tweak-schedule generator for the BipBip 24-bit pointer cipher. Accepts a 64-bit tweak, expands it against the six tweak round keys into twelve 32-bit round tweaks (`tweak_schedule_t`), and hands the finished schedule to the decryption datapath. Caches the last tweak so a repeated tweak returns its schedule in one cycle without recomputation.

## Interface
- `NUM_ROUNDS`, default 12: round tweaks produced; fixed by `tweak_schedule_t`.
- `clk_i` in, 1: clock.
- `rst_i` in, 1: reset. **Synchronous, active-high.**
- `key_i` in, `key_schedule_t`: key schedule. Only `tweak_round_key[5:0]` is used. Must be stable except in cycles where `key_update_i`=1.
- `key_update_i` in, 1: single-cycle pulse when `key_i` changes.
- `req_valid_i` in, 1: tweak request valid.
- `req_ready_o` out, 1: ready for a request.
- `tweak_i` in, `tweak_word`: tweak; sampled on the accept edge.
- `out_valid_o` out, 1: schedule valid.
- `out_ready_i` in, 1: consumer accepts the schedule.
- `sched_o` out, `tweak_schedule_t`: round tweaks `tweak_round[0..11]`.
- `hit_o` out, 1: qualifies `out_valid_o`. 1 when the schedule came from the cache.

## Operation
- **Arithmetic.** All operations are 64-bit modulo 2^64.
  - `M(S) = S ^ rotl(S,1) ^ rotl(S,8)`.
  - `S0 = tweak ^ trk[0]`.
  - For round `i` = 0..11: `T[i] = S_i[31:0] ^ S_i[63:32]`, and `S_{i+1} = M(S_i) ^ trk[(i+1) mod 6] ^ zext(i+1)`.
- **FSM states.** IDLE, RUN, DONE.
- **IDLE.**
  - `req_ready_o` = 1.
  - On `req_valid_i`, if `cache_valid` and `tweak_i == cached_tweak`, go to DONE with `hit_o`=1. The schedule registers are unchanged.
  - Otherwise, load `S` = `tweak_i ^ trk[0]`, set `cnt` = 0, latch `tweak_i` into `cached_tweak`, clear `cache_valid`, and go to RUN.
- **RUN.**
  - Each cycle: write `T[cnt]` into `sched[cnt]`, set `S` = `S_{cnt+1}`, then `cnt++`.
  - After the cycle with `cnt`=11: set `cache_valid`=1, go to DONE with `hit_o`=0.
- **DONE.**
  - `out_valid_o`=1; `sched_o` and `hit_o` are held stable.
  - On `out_ready_i`, go to IDLE.
- **`key_update_i`.**
  - Always clears `cache_valid`. This takes priority over setting it in the same cycle.
  - In RUN: restart from `S0 = cached_tweak ^ key_i.trk[0]` and `cnt`=0, using the new key.
  - In DONE: the held output stays valid until consumed. The next request for the same tweak misses.
- `req_ready_o` = (state==IDLE). It is not asserted in DONE, even if `out_ready_i`=1 in the same cycle.

## Timing
- **Reset values.** State IDLE; `req_ready_o`=1; `out_valid_o`=0; `hit_o`=0; `sched_o` all zero; `cache_valid`=0; `cnt`=0. Reset mid-RUN or mid-DONE aborts with no output.
- **Miss latency.** Accept edge E. RUN occupies cycles E+1..E+12. `out_valid_o` is high from cycle E+13.
- **Hit latency.** `out_valid_o` is high in cycle E+1.
- **Throughput.** One request per 14 cycles on a miss and 2 cycles on a hit, with `out_ready_i` tied high. The next accept is possible the cycle after the output handshake.
- **Backpressure.** DONE holds indefinitely while `out_ready_i`=0.
- **Restart cost.** A `key_update_i` in RUN adds the elapsed RUN cycles plus 1 to the latency.

## Structure
- **Additions to `bipbip_pkg`:**
  - `NUM_TWEAK_ROUNDS`=12 and `NUM_TWEAK_KEYS`=6.
  - Function `tweak_mix` (M).
  - Enum `tsched_state_e`.
- **Sub-module `bipbip_tweak_round`:** combinational. Takes `S`, `trk`, and a round index; produces `T` and the next `S`. It is reused by the unrolled low-latency variant later.
- **Top level:** FSM, 4-bit `cnt`, `S` register, 12×32 schedule register file, and cache tag (`cached_tweak`, `cache_valid`).

## Test plan
- **Zero vector.** Reset, keys 0, tweak 0. Expect `T[0]`=0, `T[1]`=0x1, `T[2]`=0x101. `out_valid_o` rises exactly 13 cycles after accept; `hit_o`=0.
- **Repeat hit.** Re-request the same tweak. Expect `out_valid_o` in the next cycle, `hit_o`=1, `sched_o` identical, and no change to the `S` register.
- **Invalidate while idle.** Pulse `key_update_i` in IDLE, then re-request the same tweak. Expect a miss, a 13-cycle latency, and a schedule recomputed with the new keys.
- **Key update mid-run.** Tweak 0xDEADBEEF_01234567, then `key_update_i` at RUN cycle 5. Expect output at E+19 that matches a golden model computed with the new key only.
- **Backpressure.** Hold `out_ready_i`=0 for 20 cycles in DONE. Expect `sched_o` stable and `req_ready_o`=0 throughout. Release, and a new request is accepted on the following cycle.
- **Reset mid-run.** Assert `rst_i` at RUN cycle 7. Expect all outputs at reset values the next cycle. The same tweak afterwards misses.

Source files
------------

// File: rtl/bipbip_pkg.sv
// Shared types and helpers for the BipBip 24-bit pointer cipher datapath.
package bipbip_pkg;

    localparam int unsigned NUM_TWEAK_ROUNDS = 12;
    localparam int unsigned NUM_TWEAK_KEYS   = 6;

    typedef logic [63:0] tweak_word;

    typedef struct packed {
        tweak_word [NUM_TWEAK_KEYS-1:0] tweak_round_key;
    } key_schedule_t;

    typedef struct packed {
        logic [NUM_TWEAK_ROUNDS-1:0][31:0] tweak_round;
    } tweak_schedule_t;

    typedef enum logic [1:0] {
        TS_IDLE = 2'd0,
        TS_RUN  = 2'd1,
        TS_DONE = 2'd2
    } tsched_state_e;

    function automatic tweak_word tweak_mix(input tweak_word s);
        return s ^ {s[62:0], s[63]} ^ {s[55:0], s[63:56]};
    endfunction

endpackage

// File: rtl/bipbip_tweak_round.sv
// One combinational tweak-schedule round: emits the round tweak for state S and the next state.
module bipbip_tweak_round
    import bipbip_pkg::*;
(
    input  tweak_word                      i_state,
    input  tweak_word [NUM_TWEAK_KEYS-1:0] i_trk,
    input  logic [3:0]                     i_round,
    output logic [31:0]                    o_tweak,
    output tweak_word                      o_state
);

    logic [3:0] w_next_round;
    logic [2:0] w_key_sel;

    always_comb begin
        w_next_round = i_round + 4'd1;
        // (round + 1) mod 6 without a divider; round + 1 never exceeds 15.
        if (w_next_round >= 4'd12) begin
            w_key_sel = 3'(w_next_round - 4'd12);
        end else if (w_next_round >= 4'd6) begin
            w_key_sel = 3'(w_next_round - 4'd6);
        end else begin
            w_key_sel = 3'(w_next_round);
        end
        o_tweak = i_state[31:0] ^ i_state[63:32];
        o_state = tweak_mix(i_state) ^ i_trk[w_key_sel] ^ tweak_word'(w_next_round);
    end

endmodule

// File: rtl/bipbip_tweak_sched.sv
// Iterative BipBip tweak-schedule generator: one round per cycle, with a
// single-entry cache so a repeated tweak returns its held schedule at once.
module bipbip_tweak_sched
    import bipbip_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_TWEAK_ROUNDS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  key_schedule_t   key_i,
    input  logic            key_update_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  tweak_word       tweak_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output tweak_schedule_t sched_o,
    output logic            hit_o
);

    localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

    tsched_state_e   r_state;
    logic [3:0]      r_cnt;
    tweak_word       r_s;
    tweak_schedule_t r_sched;
    tweak_word       r_cached_tweak;
    logic            r_cache_valid;
    logic            r_hit;

    logic [31:0]     w_round_tweak;
    tweak_word       w_next_s;
    logic            w_hit;

    bipbip_tweak_round u_round (
        .i_state (r_s),
        .i_trk   (key_i.tweak_round_key),
        .i_round (r_cnt),
        .o_tweak (w_round_tweak),
        .o_state (w_next_s)
    );

    // A key change in the request cycle makes the cached schedule stale.
    assign w_hit = r_cache_valid && !key_update_i && (tweak_i == r_cached_tweak);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= TS_IDLE;
            r_cnt          <= '0;
            r_s            <= '0;
            r_sched        <= '0;
            r_cached_tweak <= '0;
            r_cache_valid  <= 1'b0;
            r_hit          <= 1'b0;
        end else begin
            unique case (r_state)
                TS_IDLE: begin
                    if (req_valid_i) begin
                        if (w_hit) begin
                            r_hit   <= 1'b1;
                            r_state <= TS_DONE;
                        end else begin
                            r_s            <= tweak_i ^ key_i.tweak_round_key[0];
                            r_cnt          <= '0;
                            r_cached_tweak <= tweak_i;
                            r_cache_valid  <= 1'b0;
                            r_hit          <= 1'b0;
                            r_state        <= TS_RUN;
                        end
                    end
                end
                TS_RUN: begin
                    if (key_update_i) begin
                        r_s   <= r_cached_tweak ^ key_i.tweak_round_key[0];
                        r_cnt <= '0;
                    end else begin
                        r_sched.tweak_round[r_cnt] <= w_round_tweak;
                        r_s                        <= w_next_s;
                        if (r_cnt == LAST_CNT) begin
                            r_cnt         <= '0;
                            r_cache_valid <= 1'b1;
                            r_state       <= TS_DONE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                TS_DONE: begin
                    if (out_ready_i) begin
                        r_state <= TS_IDLE;
                    end
                end
                default: r_state <= TS_IDLE;
            endcase
            // Placed last so invalidation overrides a same-cycle cache fill.
            if (key_update_i) begin
                r_cache_valid <= 1'b0;
            end
        end
    end

    assign req_ready_o = (r_state == TS_IDLE);
    assign out_valid_o = (r_state == TS_DONE);
    assign hit_o       = (r_state == TS_DONE) && r_hit;
    assign sched_o     = r_sched;

endmodule
